// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern/mask.
// Optional saturating match counter enabled by SEQ_DET_COUNT_EN.
module seq_detector_param #(
    parameter int                   PATTERN_W       = 4,
    parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = 4'b1101,
    parameter logic [PATTERN_W-1:0] DEFAULT_MASK    = '1,
    parameter int                   CNT_W           = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic                               in_bit,
    input  logic                               overlap_en,
    input  logic                               load,
    input  logic [PATTERN_W-1:0]               load_pattern,
    input  logic [PATTERN_W-1:0]               load_mask,
    output logic                               match,
    output logic [$clog2(PATTERN_W+1)-1:0]     fill
`ifdef SEQ_DET_COUNT_EN
    ,
    input  logic                               clr_count,
    output logic [CNT_W-1:0]                   match_count
`endif
);

    localparam int FW = $clog2(PATTERN_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PATTERN_W);

    logic [PATTERN_W-1:0] r_pat;
    logic [PATTERN_W-1:0] r_mask;
    logic [PATTERN_W-1:0] r_hist;
    logic [FW-1:0]        r_fill;
    logic                 r_match;

    logic [PATTERN_W-1:0] w_hist_n;
    logic [FW-1:0]        w_fill_n;
    logic                 w_hit;

    // Newest bit enters at the LSB; fill saturates once the window is full.
    always_comb begin
        w_hist_n = {r_hist[PATTERN_W-2:0], in_bit};
        w_fill_n = (r_fill == FULL) ? r_fill : r_fill + FW'(1);
        w_hit    = in_valid && !load && (w_fill_n == FULL) &&
                   (((w_hist_n ^ r_pat) & r_mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat   <= DEFAULT_PATTERN;
            r_mask  <= DEFAULT_MASK;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (load) begin
            r_pat   <= load_pattern;
            r_mask  <= load_mask;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (in_valid) begin
            r_hist  <= w_hist_n;
            r_fill  <= (w_hit && !overlap_en) ? '0 : w_fill_n;
            r_match <= w_hit;
        end else begin
            r_match <= 1'b0;
        end
    end

    assign match = r_match;
    assign fill  = r_fill;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] r_count;

    // Clear beats a coincident hit; load leaves the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr_count) begin
            r_count <= '0;
        end else if (w_hit && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign match_count = r_count;
`endif

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector. It is the next generation of the fixed-pattern Moore FSM detectors in the lab set. Pattern width, pattern value and don't-care mask are set by parameter and can be reloaded at runtime. Overlapping and non-overlapping detection modes are selectable. It sits between a serial bit source with a valid strobe and downstream logic that consumes single-cycle match pulses.

Parameters:
PATTERN_W, 4, pattern length in bits (>= 2); bit PATTERN_W-1 is the first bit received.
DEFAULT_PATTERN, 4'b1101, pattern loaded at reset.
DEFAULT_MASK, all ones, reset mask; 1 = compare this bit, 0 = don't care.
CNT_W, 8, match counter width (used only with SEQ_DET_COUNT_EN).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous reset, active-high.
in_valid  input  1  in_bit is sampled on this edge when high.
in_bit  input  1  serial data bit.
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
load  input  1  loads load_pattern/load_mask and restarts detection.
load_pattern  input  PATTERN_W  new pattern value.
load_mask  input  PATTERN_W  new compare mask.
match  output  1  registered one-cycle pulse per detected occurrence.
fill  output  clog2(PATTERN_W+1)  number of valid history bits held, 0..PATTERN_W.
clr_count  input  1  synchronous counter clear (SEQ_DET_COUNT_EN only).
match_count  output  CNT_W  saturating match count (SEQ_DET_COUNT_EN only).

Behaviour:
- Clock: single clock clk. Reset: rst is asynchronous and active-high.
- Reset values: pat_reg=DEFAULT_PATTERN, mask_reg=DEFAULT_MASK, hist=0, fill=0, match=0, match_count=0.
- Priority per edge: rst > load > in_valid.
- load=1:
  - pat_reg and mask_reg take the load values; hist=0, fill=0, match=0.
  - in_valid is ignored that cycle.
  - match_count is unchanged.
- Accepting a bit (in_valid=1, load=0):
  - hist_n = {hist[PATTERN_W-2:0], in_bit}; the newest bit sits at the LSB.
  - fill_n = min(fill+1, PATTERN_W).
- Hit condition: fill_n==PATTERN_W and ((hist_n ^ pat_reg) & mask_reg)==0.
- On a hit, match=1 on the same edge that shifts in the completing bit. match is high for exactly that one following cycle.
- Latency: match is visible in the cycle immediately after the last pattern bit is sampled.
- On a hit with overlap_en=0: fill is forced to 0. The next hit needs PATTERN_W fresh valid bits.
- On a hit with overlap_en=1: fill stays at PATTERN_W, so a hit is possible on the very next valid bit.
- in_valid=0: hist and fill hold, match=0. Gaps in valid never break a partial match.
- mask_reg all zeros: with overlap_en=1, a hit on every valid bit once fill==PATTERN_W; with overlap_en=0, a hit every PATTERN_W valid bits.
- Changing overlap_en mid-stream affects only hits evaluated on that edge; no other state changes.
- Reset mid-operation clears everything immediately, independent of clk.

Optional Feature:
SEQ_DET_COUNT_EN.
- Defined:
  - clr_count and match_count exist.
  - match_count increments on each hit and saturates at 2^CNT_W-1.
  - clr_count=1 forces match_count to 0; clear wins over a simultaneous hit.
  - load does not clear the counter.
- Undefined: both ports are absent and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Reset and defaults: assert rst mid-stream -> match=0, fill=0, match_count=0 asynchronously; pattern reverts to 4'b1101.
- Overlap on: overlap_en=1, valid stream 1,1,0,1,1,0,1 -> match pulses after the 4th and 7th bits; match_count=2.
- Overlap off: overlap_en=0, valid stream 1,1,0,1,1,0,1 -> single pulse after the 4th bit; fill=3 after the 7th bit.
- Valid gaps and mask: load pattern 4'b1001, mask 4'b1011; bits 1,(idle 3 cycles),1,0,1 -> match after the last bit; fill holds at 1 during the idle cycles.
- Load mid-stream: after bits 1,1,0, assert load together with in_valid=1, in_bit=1 -> no match, fill=0, new pattern active, match_count unchanged.
- Counter saturation/clear (CNT_W=2, SEQ_DET_COUNT_EN): 5 hits -> match_count=3; clr_count coinciding with a hit -> match_count=0.
